// File: rtl/fb_arbiter.sv
// fb_arbiter: 16x16 1-bit framebuffer with a registered display read port, two write
// requesters admitted only during blanking, and a clear sweep. Macro FB_ARB_ROUND_ROBIN_EN selects round-robin ties.
//
// state | meaning
// IDLE  | display reads; writes granted while vis=0 and clr=0
// CLEAR | zeroing one row per cycle; no writes granted
module fb_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       vis,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic       rd_pix,
    input  logic       req0,
    input  logic [3:0] wx0,
    input  logic [3:0] wy0,
    input  logic       wd0,
    output logic       ack0,
    input  logic       req1,
    input  logic [3:0] wx1,
    input  logic [3:0] wy1,
    input  logic       wd1,
    output logic       ack1,
    input  logic       clr,
    output logic       busy
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    logic [15:0] fb [16];
    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic        ack0_q, ack1_q, rd_pix_q;
    logic        elig0, elig1, grant0, grant1, clear_row;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        clear_row = 1'b0;
        elig0     = 1'b0;
        elig1     = 1'b0;
        case (state_q)
            IDLE: begin
                // ack masking stops a second write while the requester drops req
                elig0 = req0 && !ack0_q && !vis && !clr;
                elig1 = req1 && !ack1_q && !vis && !clr;
                if (clr) begin
                    state_d = CLEAR;
                    row_d   = 4'd0;
                end
            end
            CLEAR: begin
                clear_row = 1'b1;
                row_d     = row_q + 4'd1;
                if (row_q == 4'd15) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FB_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;   // 1: requester 1 was served last

    assign grant0 = elig0 && (!elig1 || rr_q);
    assign grant1 = elig1 && (!elig0 || !rr_q);

    always_comb begin
        rr_d = rr_q;
        if (grant0) begin
            rr_d = 1'b0;
        end else if (grant1) begin
            rr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign grant0 = elig0;
    assign grant1 = elig1 && !elig0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= 4'd0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rd_pix_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            ack0_q   <= grant0;
            ack1_q   <= grant1;
            rd_pix_q <= fb[rd_y][rd_x];
        end
    end

    // Storage has no reset; reset only blocks the write so an aborted sweep leaves later rows intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_row) begin
                fb[row_q] <= 16'h0000;
            end else if (grant0) begin
                fb[wy0][wx0] <= wd0;
            end else if (grant1) begin
                fb[wy1][wx1] <= wd1;
            end
        end
    end

    assign rd_pix = rd_pix_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign busy   = (state_q == CLEAR);
endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized + directed bench for fb_arbiter: a pixel-array reference model queues the expected
// per-cycle outputs, and a negedge monitor compares them against the DUT.
module tb_fb_arbiter;
    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vis, clr;
    logic [3:0] rd_x, rd_y;
    logic       m_req0, m_wd0, m_req1, m_wd1;
    logic [3:0] m_wx0, m_wy0, m_wx1, m_wy1;
    logic       a_req0, a_wd0, a_req1, a_wd1;
    logic [3:0] a_wx0, a_wy0, a_wx1, a_wy1;
    logic       auto_en;
    int         dens;

    logic       req0, wd0, req1, wd1;
    logic [3:0] wx0, wy0, wx1, wy1;
    logic       rd_pix, ack0, ack1, busy;

    assign req0 = auto_en ? a_req0 : m_req0;
    assign wx0  = auto_en ? a_wx0  : m_wx0;
    assign wy0  = auto_en ? a_wy0  : m_wy0;
    assign wd0  = auto_en ? a_wd0  : m_wd0;
    assign req1 = auto_en ? a_req1 : m_req1;
    assign wx1  = auto_en ? a_wx1  : m_wx1;
    assign wy1  = auto_en ? a_wy1  : m_wy1;
    assign wd1  = auto_en ? a_wd1  : m_wd1;

    fb_arbiter dut (
        .clk(clk), .rst(rst), .vis(vis), .rd_x(rd_x), .rd_y(rd_y), .rd_pix(rd_pix),
        .req0(req0), .wx0(wx0), .wy0(wy0), .wd0(wd0), .ack0(ack0),
        .req1(req1), .wx1(wx1), .wy1(wy1), .wd1(wd1), .ack1(ack1),
        .clr(clr), .busy(busy)
    );

    // Random requesters: hold until ack, then either present the next write or drop req.
    always @(posedge clk) begin
        #1;
        if (!auto_en) begin
            a_req0 = 1'b0;
        end else if (!a_req0 || ack0) begin
            if (int'($urandom_range(0, 99)) < dens) begin
                a_req0 = 1'b1;
                a_wx0  = 4'($urandom_range(0, 15));
                a_wy0  = 4'($urandom_range(0, 15));
                a_wd0  = 1'($urandom_range(0, 1));
            end else begin
                a_req0 = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!auto_en) begin
            a_req1 = 1'b0;
        end else if (!a_req1 || ack1) begin
            if (int'($urandom_range(0, 99)) < dens) begin
                a_req1 = 1'b1;
                a_wx1  = 4'($urandom_range(0, 15));
                a_wy1  = 4'($urandom_range(0, 15));
                a_wd1  = 1'($urandom_range(0, 1));
            end else begin
                a_req1 = 1'b0;
            end
        end
    end

    // Reference model: one expected-output record per clock edge.
    typedef struct packed {
        bit ack0;
        bit ack1;
        bit busy;
        bit rd;
        bit known;
    } exp_t;

    exp_t expq[$];
    bit   pix   [16][16];
    bit   known [16][16];
    bit   sweeping = 1'b0;
    int   next_row = 0;
    bit   mack0 = 1'b0, mack1 = 1'b0;
`ifdef FB_ARB_ROUND_ROBIN_EN
    bit   last1 = 1'b0;
`endif

    always @(posedge clk) begin
        exp_t e;
        bit   e0, e1, g0, g1;
        e       = '0;
        e.known = known[rd_y][rd_x];
        e.rd    = pix[rd_y][rd_x];
        g0      = 1'b0;
        g1      = 1'b0;
        if (rst) begin
            e.rd     = 1'b0;
            e.known  = 1'b1;
            sweeping = 1'b0;
            next_row = 0;
`ifdef FB_ARB_ROUND_ROBIN_EN
            last1    = 1'b0;
`endif
        end else if (sweeping) begin
            for (int c = 0; c < 16; c++) begin
                pix[next_row][c]   = 1'b0;
                known[next_row][c] = 1'b1;
            end
            next_row++;
            if (next_row == 16) begin
                sweeping = 1'b0;
                next_row = 0;
            end
        end else if (clr) begin
            sweeping = 1'b1;
            next_row = 0;
        end else begin
            e0 = req0 && !mack0 && !vis;
            e1 = req1 && !mack1 && !vis;
            if (e0 && e1) begin
`ifdef FB_ARB_ROUND_ROBIN_EN
                if (last1) g0 = 1'b1;
                else       g1 = 1'b1;
`else
                g0 = 1'b1;
`endif
            end else begin
                g0 = e0;
                g1 = e1;
            end
            if (g0) begin
                pix[wy0][wx0]   = wd0;
                known[wy0][wx0] = 1'b1;
            end else if (g1) begin
                pix[wy1][wx1]   = wd1;
                known[wy1][wx1] = 1'b1;
            end
`ifdef FB_ARB_ROUND_ROBIN_EN
            if (g0)      last1 = 1'b0;
            else if (g1) last1 = 1'b1;
`endif
        end
        mack0  = g0;
        mack1  = g1;
        e.ack0 = g0;
        e.ack1 = g1;
        e.busy = sweeping;
        expq.push_back(e);
    end

    // Monitor / scoreboard
    int vectors = 0, miscompares = 0, rd_idx = 0, tmo_seen = 0;
    int tmo_cnt = 0;

    task automatic chk(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s entry=%0d got=%0b expected=%0b", name, rd_idx, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (tmo_seen < tmo_cnt) begin
            vectors++;
            miscompares++;
            tmo_seen++;
        end
        if (rd_idx < expq.size()) begin
            e = expq[rd_idx];
            chk("ack0", ack0, e.ack0);
            chk("ack1", ack1, e.ack1);
            chk("busy", busy, e.busy);
            if (e.known) chk("rd_pix", rd_pix, e.rd);
            rd_idx++;
        end
    end

    // Stimulus
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int n, input int maxc);
        bit got = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            step(1);
            if ((n == 0) ? ack0 : ack1) got = 1'b1;
        end
        if (!got) begin
            $display("FAIL wait_ack%0d no ack within %0d cycles, got=0 expected=1", n, maxc);
            tmo_cnt++;
        end
    endtask

    task automatic mwrite(input int n, input logic [3:0] x, input logic [3:0] y, input logic d);
        if (n == 0) begin
            m_wx0 = x; m_wy0 = y; m_wd0 = d; m_req0 = 1'b1;
        end else begin
            m_wx1 = x; m_wy1 = y; m_wd1 = d; m_req1 = 1'b1;
        end
        wait_ack(n, 40);
        if (n == 0) m_req0 = 1'b0;
        else        m_req1 = 1'b0;
    endtask

    task automatic read_sweep();
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                rd_y = 4'(y);
                rd_x = 4'(x);
                step(1);
            end
        end
        step(1);
    endtask

    initial begin
        rst = 1'b1; vis = 1'b0; clr = 1'b0; rd_x = 4'd0; rd_y = 4'd0;
        m_req0 = 1'b0; m_wx0 = 4'd0; m_wy0 = 4'd0; m_wd0 = 1'b0;
        m_req1 = 1'b0; m_wx1 = 4'd0; m_wy1 = 4'd0; m_wd1 = 1'b0;
        auto_en = 1'b0; dens = 0;
        step(3);
        rst = 1'b0;

        clr = 1'b1; step(1); clr = 1'b0;
        step(20);
        read_sweep();

        mwrite(0, 4'd3, 4'd5, 1'b1);
        rd_x = 4'd3; rd_y = 4'd5; step(1);
        rd_x = 4'd4; step(2);

        vis = 1'b1;
        m_wx1 = 4'd10; m_wy1 = 4'd2; m_wd1 = 1'b1; m_req1 = 1'b1;
        step(10);
        vis = 1'b0;
        wait_ack(1, 3);
        m_req1 = 1'b0;
        rd_x = 4'd10; rd_y = 4'd2; step(2);

        m_wx0 = 4'd7; m_wy0 = 4'd9; m_wd0 = 1'b1; m_req0 = 1'b1; clr = 1'b1;
        step(1);
        clr = 1'b0;
        wait_ack(0, 30);
        m_req0 = 1'b0;
        rd_x = 4'd7; rd_y = 4'd9; step(2);

        auto_en = 1'b1; dens = 100;
        step(20);
        dens = 0;
        step(10);
        auto_en = 1'b0;
        step(1);

        auto_en = 1'b1; dens = 50;
        for (int i = 0; i < 2000; i++) begin
            vis  = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 199) == 0);
            rd_x = 4'($urandom_range(0, 15));
            rd_y = 4'($urandom_range(0, 15));
            step(1);
        end
        vis = 1'b0; clr = 1'b0; dens = 0;
        step(40);
        auto_en = 1'b0;
        step(1);

        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                mwrite((x + y) % 2, 4'(x), 4'(y), 1'b1);
            end
        end
        rd_x = 4'd0; rd_y = 4'd0;
        step(1);
        clr = 1'b1; step(1); clr = 1'b0;
        step(4);
        rst = 1'b1; step(1); rst = 1'b0;
        read_sweep();

        step(2);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Owner of the 16x16 1-bit pixel framebuffer that feeds the VGA timing generator's red channel. Serves one display read per clock and shares the single write port between two write requesters via req/ack handshakes. Writes are admitted only while the display is in blanking. Includes a clear engine that zeroes the whole buffer on command.

## Interface
Parameters: none; geometry is fixed at 16 rows x 16 columns, 1 bit per pixel.

- clk  in  1  clock, the pixel clock shared with the VGA timing generator
- rst  in  1  synchronous, active-high reset
- vis  in  1  display is in its visible region; writes are blocked while high
- rd_x  in  4  display read column
- rd_y  in  4  display read row
- rd_pix  out  1  registered pixel at (rd_y, rd_x)
- req0  in  1  write request, requester 0
- wx0, wy0  in  4 each  requester 0 column and row
- wd0  in  1  requester 0 write data
- ack0  out  1  one-cycle pulse: requester 0 write committed
- req1, wx1, wy1, wd1, ack1  same as above, for requester 1
- clr  in  1  start a clear sweep
- busy  out  1  clear sweep in progress

## Operation
- Storage is fb[row][col], 16x16 bits. Storage has no reset; contents are undefined until the first clear.
- The FSM has two states, IDLE and CLEAR. Reset goes to IDLE.
- Reset values: rd_pix=0, ack0=0, ack1=0, busy=0, row counter=0, round-robin pointer=0 (requester 0 was last served).
- Read path:
  - rd_pix <= fb[rd_y][rd_x] on every cycle, in every state, regardless of vis.
- Write eligibility in IDLE: requester n is eligible when reqn=1, ackn=0, vis=0 and clr=0.
  - Masking by ackn prevents a double write while the requester drops req.
- Grant:
  - When exactly one requester is eligible, it is granted.
  - When both are eligible, the choice depends on the arbitration mode (see Configuration).
  - The granted write commits fb[wyn][wxn] <= wdn at the clock edge.
  - ackn is registered and is high in the following cycle only.
- Requester rules:
  - Hold reqn, wxn, wyn and wdn stable until ackn is sampled high.
  - Deassert reqn, or present the next write, in the cycle ackn is high.
- Requests are not queued. A request stays pending while vis=1, during CLEAR, or while it loses arbitration.
- IDLE to CLEAR:
  - Triggered by clr=1 in IDLE; clr has priority over any write that cycle.
  - busy=1 from the next cycle.
- In CLEAR:
  - One row per cycle: fb[row] <= 16'h0000, then row increments.
  - The sweep ignores vis and grants no writes.
  - clr is ignored.
  - After row 15 is written: state returns to IDLE, row returns to 0, busy=0 in the following cycle.
- rst during CLEAR aborts the sweep. Rows not yet cleared keep their contents.

## Timing
- Read latency: 1 cycle from rd_x/rd_y to rd_pix.
- Same-edge read and write to the same address: rd_pix returns the old value. The new value is visible one cycle later.
- Write: a request eligible in cycle t commits at the end of cycle t, and ackn=1 in cycle t+1.
- Minimum spacing per requester: one write every 2 cycles.
- Both requesters together: one write per cycle.
- Clear: clr sampled in cycle t; busy=1 in cycles t+1 through t+16; rows 0..15 are cleared at the ends of cycles t+1..t+16; busy=0 in cycle t+17.
- A write request pending during the sweep can be acked at the earliest in cycle t+18.
- vis rising in the same cycle as a request blocks that request. No partial writes occur.

## Configuration
- FB_ARB_ROUND_ROBIN_EN defined:
  - When both requesters are eligible, the one not last served is granted.
  - The pointer updates on every grant.
- Undefined:
  - Fixed priority: requester 0 always wins ties.
  - The pointer logic is removed.
  - Requester 1 can be starved by back-to-back requester 0 traffic, up to every other cycle because of ack masking.

## Test plan
- Reset, then clr pulse -> busy high for exactly 16 cycles; a subsequent read sweep of all 256 addresses returns 0.
- vis=0, req0 writing (3,5)=1 -> ack0 one cycle later; rd_x=3, rd_y=5 gives rd_pix=1 one cycle after the address is applied; the neighbouring pixel (4,5) reads 0.
- vis=1, req1 held for 10 cycles, then vis=0 -> no ack1 while vis=1; ack1 arrives exactly 1 cycle after vis falls; the write lands.
- Both requesters hold requests continuously at different addresses with vis=0 -> with the macro defined, grants alternate 0,1,0,1; without it, ack0 on every other cycle and ack1 only in the gaps.
- clr and req0 asserted in the same cycle -> no ack0 during CLEAR; ack0 one cycle after busy falls.
- rst asserted 5 cycles into a sweep over a buffer of all 1s -> rows 0–3 read 0, rows 4–15 read 1, busy=0, rd_pix=0 immediately after reset.
